// File: rtl/slot_sequencer.sv
// Slot sequencer: walks SLOTS packed opcodes per fetched instruction word and
// drives registered datapath strobes, mux selects, memory handshake and IO control.
module slot_sequencer #(
   parameter int SLOTS         = 4,
   parameter int SLOTW         = 2,
   parameter bit MEM_WAIT      = 1'b1,
   parameter bit FLUSH_ON_JUMP = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [3:0]       insn,
   input  logic             accz,
   input  logic             accn,
   input  logic             iobusy,
   input  logic             mem_ready,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             ip_write,
   output logic             acc_write,
   output logic             seladdr,
   output logic [1:0]       selacc,
   output logic             selswap,
   output logic             doswap,
   output logic             selip1,
   output logic             selip2,
   output logic [1:0]       aluinsn,
   output logic [SLOTW-1:0] curslot,
   output logic             runio,
   output logic             halted
);

   typedef enum logic [2:0] {
      S_FETCH, S_FWAIT, S_LATCH, S_DECODE, S_MWAIT, S_IOWAIT, S_NEXT, S_HALT
   } state_t;

   typedef enum logic [3:0] {
      OP_NOP     = 4'd0,  OP_SYSCALL = 4'd1,  OP_LOAD  = 4'd2,  OP_STORE = 4'd3,
      OP_SWAPA   = 4'd4,  OP_SWAPD   = 4'd5,  OP_BRZ   = 4'd6,  OP_BRN   = 4'd7,
      OP_JUMP    = 4'd8,  OP_CONST   = 4'd9,  OP_ADD   = 4'd10, OP_SUB   = 4'd11,
      OP_MUL     = 4'd12, OP_DIV     = 4'd13
   } opcode_t;

   state_t state;
   logic   ready;
   logic   acc_on_done;   // LOAD/CONST: pulse acc_write when memory completes
   logic   ip_on_done;    // CONST: also step IP past the literal word
   logic   io_first;
   logic   taken;
   logic   last_slot;

   assign ready     = mem_ready | ~MEM_WAIT;
   assign last_slot = (curslot == SLOTW'(SLOTS - 1));

   // NOTE: non-blocking assignments only; every output is a flop, so the
   // datapath never sees decode glitches and mem_ready has no comb path out.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= S_FETCH;
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         ir_write    <= 1'b0;
         ip_write    <= 1'b0;
         acc_write   <= 1'b0;
         seladdr     <= 1'b0;
         selacc      <= 2'd0;
         selswap     <= 1'b0;
         doswap      <= 1'b0;
         selip1      <= 1'b0;
         selip2      <= 1'b0;
         aluinsn     <= 2'd0;
         curslot     <= '0;
         runio       <= 1'b0;
         halted      <= 1'b0;
         acc_on_done <= 1'b0;
         ip_on_done  <= 1'b0;
         io_first    <= 1'b0;
         taken       <= 1'b0;
      end else begin
         case (state)
            S_FETCH: begin
               mem_read <= 1'b1;
               seladdr  <= 1'b0;
               curslot  <= '0;
               state    <= S_FWAIT;
            end
            S_FWAIT: begin
               if (ready) begin
                  mem_read <= 1'b0;
                  ir_write <= 1'b1;
                  ip_write <= 1'b1;
                  selip1   <= 1'b0;
                  state    <= S_LATCH;
               end
            end
            S_LATCH: begin
               ir_write <= 1'b0;
               ip_write <= 1'b0;
               state    <= S_DECODE;
            end
            S_DECODE: begin
               taken       <= 1'b0;
               acc_on_done <= 1'b0;
               ip_on_done  <= 1'b0;
               state       <= S_NEXT;
               case (opcode_t'(insn))
                  OP_NOP: state <= S_NEXT;
                  OP_SYSCALL: begin
                     runio    <= 1'b1;
                     selacc   <= 2'd1;
                     io_first <= 1'b1;
                     state    <= S_IOWAIT;
                  end
                  OP_LOAD: begin
                     mem_read    <= 1'b1;
                     seladdr     <= 1'b1;
                     selacc      <= 2'd0;
                     acc_on_done <= 1'b1;
                     state       <= S_MWAIT;
                  end
                  OP_STORE: begin
                     mem_write <= 1'b1;
                     seladdr   <= 1'b1;
                     state     <= S_MWAIT;
                  end
                  OP_CONST: begin
                     mem_read    <= 1'b1;
                     seladdr     <= 1'b0;
                     selacc      <= 2'd0;
                     acc_on_done <= 1'b1;
                     ip_on_done  <= 1'b1;
                     state       <= S_MWAIT;
                  end
                  OP_SWAPA, OP_SWAPD: begin
                     acc_write <= 1'b1;
                     selacc    <= 2'd2;
                     doswap    <= 1'b1;
                     selswap   <= (insn == OP_SWAPD);
                  end
                  OP_BRZ, OP_BRN: begin
                     if ((insn == OP_BRZ && accz) || (insn == OP_BRN && accn)) begin
                        ip_write <= 1'b1;
                        selip1   <= 1'b1;
                        selip2   <= 1'b0;
                        taken    <= 1'b1;
                     end
                  end
                  OP_JUMP: begin
                     ip_write <= 1'b1;
                     selip1   <= 1'b1;
                     selip2   <= 1'b1;
                     taken    <= 1'b1;
                  end
                  OP_ADD, OP_SUB, OP_MUL, OP_DIV: begin
                     aluinsn   <= 2'(insn - 4'd10);
                     acc_write <= 1'b1;
                     selacc    <= 2'd3;
                  end
                  default: begin
                     halted    <= 1'b1;
                     mem_read  <= 1'b0;
                     mem_write <= 1'b0;
                     ir_write  <= 1'b0;
                     ip_write  <= 1'b0;
                     acc_write <= 1'b0;
                     doswap    <= 1'b0;
                     runio     <= 1'b0;
                     state     <= S_HALT;
                  end
               endcase
            end
            S_MWAIT: begin
               if (ready) begin
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  if (acc_on_done) acc_write <= 1'b1;
                  if (ip_on_done) begin
                     ip_write <= 1'b1;
                     selip1   <= 1'b0;
                  end
                  state <= S_NEXT;
               end
            end
            S_IOWAIT: begin
               // The IO unit needs a cycle to raise iobusy after runio goes high.
               io_first <= 1'b0;
               if (!io_first && !iobusy) begin
                  runio     <= 1'b0;
                  acc_write <= 1'b1;
                  selacc    <= 2'd1;
                  state     <= S_NEXT;
               end
            end
            S_NEXT: begin
               mem_read  <= 1'b0;
               mem_write <= 1'b0;
               ir_write  <= 1'b0;
               ip_write  <= 1'b0;
               acc_write <= 1'b0;
               doswap    <= 1'b0;
               if (last_slot || (FLUSH_ON_JUMP && taken)) begin
                  state <= S_FETCH;
               end else begin
                  curslot <= curslot + SLOTW'(1);
                  state   <= S_DECODE;
               end
            end
            S_HALT:  state <= S_HALT;
            default: state <= S_HALT;
         endcase
      end
   end

endmodule

// File: tb/tb_slot_sequencer.sv
// Directed bench for slot_sequencer: a flushing instance and a non-flushing
// instance share stimulus; each slot's opcode comes from a bench-held word.
module tb_slot_sequencer;

   localparam logic [3:0] NOP = 4'd0, SYSCALL = 4'd1, LOAD = 4'd2, STORE = 4'd3,
                          SWAPD = 4'd5, BRZ = 4'd6, BRN = 4'd7, JUMP = 4'd8,
                          CONST = 4'd9, ADD = 4'd10, SUB = 4'd11, ILL = 4'd15;

   logic       clock, reset;
   logic       accz, accn, iobusy, mem_ready;
   logic [3:0] word [4];
   logic [3:0] insn, nf_insn;

   logic       mem_read, mem_write, ir_write, ip_write, acc_write, seladdr;
   logic [1:0] selacc, aluinsn, curslot;
   logic       selswap, doswap, selip1, selip2, runio, halted;

   logic       nf_mem_read, nf_mem_write, nf_ir_write, nf_ip_write, nf_acc_write, nf_seladdr;
   logic [1:0] nf_selacc, nf_aluinsn, nf_curslot;
   logic       nf_selswap, nf_doswap, nf_selip1, nf_selip2, nf_runio, nf_halted;

   logic [17:0] outs;
   logic [6:0]  strobes, strobe_seen;
   int          n_checks = 0, n_errors = 0, ir_pulses = 0;
   logic        halt_low;

   assign insn    = word[curslot];
   assign nf_insn = word[nf_curslot];
   assign outs    = {mem_read, mem_write, ir_write, ip_write, acc_write, seladdr, selacc,
                     selswap, doswap, selip1, selip2, aluinsn, curslot, runio, halted};
   assign strobes = {mem_read, mem_write, ir_write, ip_write, acc_write, doswap, runio};

   slot_sequencer dut (
      .clock(clock), .reset(reset), .insn(insn), .accz(accz), .accn(accn),
      .iobusy(iobusy), .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
      .ir_write(ir_write), .ip_write(ip_write), .acc_write(acc_write), .seladdr(seladdr),
      .selacc(selacc), .selswap(selswap), .doswap(doswap), .selip1(selip1),
      .selip2(selip2), .aluinsn(aluinsn), .curslot(curslot), .runio(runio), .halted(halted)
   );

   slot_sequencer #(.FLUSH_ON_JUMP(1'b0)) dut_nf (
      .clock(clock), .reset(reset), .insn(nf_insn), .accz(accz), .accn(accn),
      .iobusy(iobusy), .mem_ready(mem_ready), .mem_read(nf_mem_read),
      .mem_write(nf_mem_write), .ir_write(nf_ir_write), .ip_write(nf_ip_write),
      .acc_write(nf_acc_write), .seladdr(nf_seladdr), .selacc(nf_selacc),
      .selswap(nf_selswap), .doswap(nf_doswap), .selip1(nf_selip1), .selip2(nf_selip2),
      .aluinsn(nf_aluinsn), .curslot(nf_curslot), .runio(nf_runio), .halted(nf_halted)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clock);
      if (ir_write) ir_pulses++;
   endtask

   task automatic set_word(input logic [3:0] s0, s1, s2, s3);
      word[0] = s0; word[1] = s1; word[2] = s2; word[3] = s3;
   endtask

   // Releases the instruction word held in FWAIT and steps through LATCH.
   task automatic load_word();
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      step();
   endtask

   initial begin
      reset = 1'b1; mem_ready = 1'b0; iobusy = 1'b0; accz = 1'b0; accn = 1'b0;
      set_word(NOP, NOP, NOP, NOP);
      #1 reset = 1'b0;
      #2 check("rst_async_zero", 32'(outs), 32'h0);
      step(); step();
      check("rst_hold_zero", 32'(outs), 32'h0);

      // ADD,SUB,NOP,NOP with a three-cycle fetch stall
      set_word(ADD, SUB, NOP, NOP);
      reset = 1'b1;
      ir_pulses = 0;
      step();
      check("fetch_rd", {mem_read, seladdr, 6'(curslot)}, {1'b1, 1'b0, 6'd0});
      repeat (3) begin
         step();
         check("fwait_hold", {mem_read, ir_write}, 2'b10);
      end
      mem_ready = 1'b1;
      step();
      check("fwait_done", {mem_read, ir_write, ip_write, selip1}, 4'b0110);
      mem_ready = 1'b0;
      step();
      check("latch_clr", {ir_write, ip_write}, 2'b00);
      step();
      check("add_dec", {acc_write, aluinsn, selacc, curslot}, {1'b1, 2'd0, 2'd3, 2'd0});
      step();
      check("add_next", {acc_write, curslot}, {1'b0, 2'd1});
      step();
      check("sub_dec", {acc_write, aluinsn, curslot}, {1'b1, 2'd1, 2'd1});
      step();
      check("slot2", 32'(curslot), 32'd2);
      step(); step();
      check("slot3", 32'(curslot), 32'd3);
      step(); step(); step();
      check("refetch", {mem_read, curslot}, {1'b1, 2'd0});
      check("ir_once", 32'(ir_pulses), 32'd1);

      // LOAD in slot 1 with a two-cycle memory stall
      set_word(NOP, LOAD, NOP, NOP);
      load_word();
      step(); step(); step();
      check("load_dec", {mem_read, seladdr, selacc, curslot}, {1'b1, 1'b1, 2'd0, 2'd1});
      step();
      check("load_wait1", {mem_read, seladdr, acc_write}, 3'b110);
      step();
      check("load_wait2", {mem_read, seladdr, acc_write}, 3'b110);
      mem_ready = 1'b1;
      step();
      check("load_done", {mem_read, acc_write}, 2'b01);
      mem_ready = 1'b0;
      step();
      check("load_next", {acc_write, curslot}, {1'b0, 2'd2});
      repeat (5) step();
      check("load_refetch", {mem_read, curslot}, {1'b1, 2'd0});

      // JUMP in slot 0: flushing instance refetches, the other keeps decoding
      set_word(JUMP, ADD, NOP, NOP);
      load_word();
      step();
      check("jump_dec", {ip_write, selip1, selip2}, 3'b111);
      check("jump_dec_nf", {nf_ip_write, nf_selip1, nf_selip2}, 3'b111);
      step();
      check("jump_next", 32'(ip_write), 32'd0);
      step();
      check("jump_flush", {mem_read, acc_write, curslot}, {1'b1, 1'b0, 2'd0});
      check("jump_noflush", {nf_acc_write, nf_curslot, nf_mem_read}, {1'b1, 2'd1, 1'b0});
      repeat (6) step();
      check("noflush_refetch", {nf_mem_read, nf_curslot}, {1'b1, 2'd0});

      // BRANCHN not taken, BRANCHZ taken
      set_word(BRN, BRZ, ADD, NOP);
      accz = 1'b1; accn = 1'b0;
      load_word();
      step();
      check("brn_not_taken", 32'(ip_write), 32'd0);
      step(); step();
      check("brz_taken", {ip_write, selip1, selip2, curslot}, {3'b110, 2'd1});
      step(); step();
      check("brz_flush", {mem_read, curslot}, {1'b1, 2'd0});
      accz = 1'b0;
      repeat (6) step();
      check("nf_resync", {nf_mem_read, nf_curslot}, {1'b1, 2'd0});

      // SYSCALL with iobusy high, then SYSCALL with iobusy already low
      set_word(SYSCALL, SYSCALL, NOP, NOP);
      iobusy = 1'b1;
      load_word();
      step();
      check("sys_dec", {runio, selacc, acc_write}, {1'b1, 2'd1, 1'b0});
      repeat (5) begin
         step();
         check("sys_busy", {runio, acc_write}, 2'b10);
      end
      iobusy = 1'b0;
      step();
      check("sys_done", {runio, acc_write, selacc}, {1'b0, 1'b1, 2'd1});
      step();
      check("sys_next", {acc_write, curslot}, {1'b0, 2'd1});
      step();
      check("sys2_dec", 32'(runio), 32'd1);
      step();
      check("io_first_ignored", {runio, acc_write}, 2'b10);
      step();
      check("sys2_done", {runio, acc_write}, 2'b01);
      repeat (6) step();
      check("sys_refetch", {mem_read, curslot}, {1'b1, 2'd0});

      // CONST in the last slot
      set_word(ADD, NOP, NOP, CONST);
      load_word();
      repeat (7) step();
      check("const_dec", {mem_read, seladdr, selacc, curslot}, {1'b1, 1'b0, 2'd0, 2'd3});
      mem_ready = 1'b1;
      step();
      check("const_done", {mem_read, acc_write, ip_write, selip1}, 4'b0110);
      mem_ready = 1'b0;
      step();
      check("const_next", {acc_write, ip_write}, 2'b00);
      step();
      check("const_refetch", {mem_read, curslot}, {1'b1, 2'd0});

      // STORE, SWAPD, then illegal opcode in slot 2
      set_word(STORE, SWAPD, ILL, NOP);
      load_word();
      step();
      check("store_dec", {mem_write, seladdr, mem_read}, 3'b110);
      mem_ready = 1'b1;
      step();
      check("store_done", {mem_write, acc_write, ip_write}, 3'b000);
      mem_ready = 1'b0;
      step(); step();
      check("swapd_dec", {acc_write, doswap, selswap, selacc}, {3'b111, 2'd2});
      step(); step();
      check("ill_halt", {halted, strobes}, {1'b1, 7'd0});
      strobe_seen = '0;
      halt_low    = 1'b0;
      for (int i = 0; i < 20; i++) begin
         mem_ready = i[0];
         iobusy    = i[1];
         step();
         strobe_seen |= strobes;
         if (!halted) halt_low = 1'b1;
      end
      mem_ready = 1'b0; iobusy = 1'b0;
      check("halt_quiet", {halt_low, strobe_seen}, 8'd0);
      reset = 1'b0;
      #1 check("halt_reset", {halted, nf_halted}, 2'b00);

      // Reset asserted mid-LOAD while mem_read is high
      set_word(LOAD, NOP, NOP, NOP);
      step();
      reset = 1'b1;
      step();
      check("fetch_after_halt", {mem_read, curslot}, {1'b1, 2'd0});
      load_word();
      step(); step();
      check("load_pending", {mem_read, seladdr}, 2'b11);
      #2 reset = 1'b0;
      #1 check("rst_mid_load", 32'(outs), 32'h0);
      step();
      reset = 1'b1;
      #1 check("rst_release_hold", 32'(outs), 32'h0);
      step();
      check("post_rst_fetch", {mem_read, seladdr, curslot}, {1'b1, 1'b0, 2'd0});

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/slot_sequencer.md
Name: slot_sequencer

Overview:
- Parametrised successor to the Sextium III instruction controller.
- Sequences SLOTS packed opcodes per fetched instruction word and drives the datapath strobes and multiplexer selects.
- Adds a memory-ready handshake, an optional refetch after a taken control transfer, and an illegal-opcode halt.
- Sits between the instruction register/slot mux (which returns `insn` for `curslot`) and the datapath, memory and IO unit.

Parameters:
- SLOTS, 4: opcodes per instruction word; any value ≥2.
- SLOTW, 2: width of `curslot`; must equal clog2(SLOTS).
- MEM_WAIT, 1: 1 = memory accesses wait for `mem_ready`; 0 = `mem_ready` is treated as constant 1.
- FLUSH_ON_JUMP, 1: 1 = a taken BRANCHZ, BRANCHN or JUMP refetches immediately; 0 = the remaining slots still execute.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- insn  in  4  opcode of the current slot.
- accz  in  1  ACC is zero.
- accn  in  1  ACC is negative.
- iobusy  in  1  IO unit busy.
- mem_ready  in  1  memory access complete this cycle.
- mem_read, mem_write, ir_write, ip_write, acc_write  out  1 each  datapath strobes.
- seladdr  out  1  address select: 0 IP, 1 AR.
- selacc  out  2  ACC source: 0 MEM, 1 IO, 2 SWAP, 3 ALU.
- selswap  out  1  swap source: 0 AR, 1 DR.
- doswap  out  1  perform swap.
- selip1  out  1  IP source: 0 next, 1 reg.
- selip2  out  1  IP register source: 0 AR, 1 ACC.
- aluinsn  out  2  ALU op: 0 add, 1 sub, 2 mul, 3 div.
- curslot  out  SLOTW  current slot index.
- runio  out  1  start/hold IO operation.
- halted  out  1  controller stopped on an illegal opcode.

Behaviour:
- General:
  - All outputs are registered.
  - While `reset` is low, every output is 0 and state = FETCH, immediately (asynchronous), including mid-access. Outputs hold until the next clock after reset deasserts.
- Opcodes: 0 NOP, 1 SYSCALL, 2 LOAD, 3 STORE, 4 SWAPA, 5 SWAPD, 6 BRANCHZ, 7 BRANCHN, 8 JUMP, 9 CONST, 10 ADD, 11 SUB, 12 MUL, 13 DIV, 14–15 illegal.
- FETCH: mem_read=1, seladdr=0, curslot=0 → FWAIT.
- FWAIT: on mem_ready: mem_read=0, ir_write=1, ip_write=1, selip1=0 → LATCH. Otherwise hold.
- LATCH: ir_write=0, ip_write=0 → DECODE.
- DECODE, by opcode:
  - NOP → NEXT.
  - SYSCALL: runio=1, selacc=1 → IOWAIT.
  - LOAD: mem_read=1, seladdr=1, selacc=0 → MWAIT.
  - STORE: mem_write=1, seladdr=1 → MWAIT.
  - CONST: mem_read=1, seladdr=0, selacc=0 → MWAIT.
  - SWAPA / SWAPD: acc_write=1, selacc=2, doswap=1, selswap=0 / 1 → NEXT.
  - BRANCHZ (accz) or BRANCHN (accn): ip_write=1, selip1=1, selip2=0. Not taken: no strobes. → NEXT.
  - JUMP: ip_write=1, selip1=1, selip2=1 → NEXT.
  - ADD / SUB / MUL / DIV: aluinsn=0 / 1 / 2 / 3, acc_write=1, selacc=3 → NEXT.
  - Illegal (14–15): halted=1, all strobes 0 → HALT.
- MWAIT: mem_read/mem_write held until mem_ready. In that cycle they drop. LOAD and CONST also pulse acc_write=1; CONST also pulses ip_write=1 with selip1=0 → NEXT.
- IOWAIT:
  - iobusy is ignored in the first IOWAIT cycle.
  - Thereafter, when iobusy=0: runio=0 and acc_write=1 (selacc=1) for one cycle → NEXT.
- NEXT:
  - Clears mem_read, mem_write, ir_write, ip_write, acc_write, doswap.
  - If curslot==SLOTS-1, or FLUSH_ON_JUMP=1 and a control transfer was taken in this slot → FETCH.
  - Otherwise curslot+1 → DECODE.
- HALT: absorbing; only reset leaves it.
- Every strobe is a single-cycle pulse except mem_read/mem_write during waits and runio.
- selacc, selswap, selip1, selip2 and aluinsn hold their last value when not rewritten.
- mem_ready arriving in the same cycle as the request is sampled next cycle (no combinational path).
- CONST in the last slot reads the word after the current IP, as in a normal CONST.

Test Plan:
- Reset low mid-LOAD with mem_read=1 → all outputs 0 immediately. After release, the first clock gives FETCH with mem_read=1 and curslot=0.
- SLOTS=4, MEM_WAIT=1, word {ADD,SUB,NOP,NOP}, mem_ready low for 3 cycles in FWAIT → ir_write pulses exactly once after mem_ready. Then acc_write pulses with aluinsn 0, then 1; curslot steps 0,1,2,3, then FETCH.
- LOAD in slot 1 with mem_ready delayed 2 cycles → mem_read=1 and seladdr=1 held 3 cycles. acc_write is a 1-cycle pulse coincident with mem_read falling.
- FLUSH_ON_JUMP=1, JUMP in slot 0 → ip_write=1, selip2=1, then FETCH (slots 1–3 skipped). FLUSH_ON_JUMP=0 → slots 1–3 still decode.
- SYSCALL with iobusy high for 5 cycles → runio high until iobusy low, then acc_write pulse with selacc=1.
- Opcode 15 in slot 2 → halted=1, no further strobes for 20 cycles; reset clears halted.
